instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly upstream of the `cpu` execute core. It reads the byte-wide instruction ROM one byte per cycle and assembles big-endian 24-bit instruction words. Assembled words are buffered in a small FIFO and handed to the core over a valid/ready handshake, tagged with their byte address. A redirect input from the core (call, exit, taken brez) flushes all buffered and in-flight state and restarts fetch at a new address.

## Interface
- ADDRESS_WIDTH, 15, width of the instruction pointer and ROM byte address
- QUEUE_DEPTH, 2, number of assembled instructions buffered (≥1)
- RESET_VECTOR, 0, first fetch address after reset
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset; one clock domain
- rom_address  out  ADDRESS_WIDTH  byte address of ROM read
- rom_read  out  1  read strobe
- rom_data  in  8  ROM byte for the read issued in the previous cycle
- instruction  out  24  assembled word, first byte in [23:16]
- instruction_address  out  ADDRESS_WIDTH  address of the word's first byte
- instruction_valid  out  1  head of FIFO is valid
- instruction_ready  in  1  core accepts head this edge
- redirect  in  1  flush and restart
- redirect_address  in  ADDRESS_WIDTH  restart address

## Operation
- Reset (async assert, held while reset=0): fetch pointer = RESET_VECTOR, FIFO empty, assembly cleared, all outputs 0.
- All outputs are registered. rom_read and rom_address are driven from flops.
- Byte pipeline: a read issued in cycle C returns rom_data in C+1, which is sampled at the end of C+1.
- Assembly FSM has states BYTE0, BYTE1 and BYTE2. Each returned byte is placed in [23:16], then [15:8], then [7:0]. The third byte pushes {word, first-byte address} into the FIFO.
- Slot reservation: the first byte of a new instruction is issued only if FIFO count + (assembly in progress ? 1 : 0) < QUEUE_DEPTH. A pop in the same cycle does not free a slot until the next cycle.
- Once an instruction starts, its remaining two bytes are always issued back-to-back.
- Fetch pointer increments by 1 per issued byte, modulo 2^ADDRESS_WIDTH. An instruction may straddle the wrap: bytes at max, 0, 1.
- Handshake: a pop occurs at an edge where instruction_valid & instruction_ready are both 1.
  - The head is stable while valid & !ready.
  - FIFO order is preserved. Push and pop may occur on the same edge.
- Redirect, sampled at edge E, overrides everything:
  - FIFO is emptied, assembly returns to BYTE0, and pointer = redirect_address.
  - Any byte returning after E from a read issued before E is discarded.
  - A handshake at E still counts as consumed by the core; it is never re-presented.
  - Redirect held high for N cycles restarts at each edge.

## Timing
- Reset release, or redirect at edge E:
  - rom_read=1 with address A in the cycle after E, then A+1 and A+2 in the next two cycles.
  - Bytes are sampled at E+2, E+3 and E+4.
  - instruction_valid=1 in the cycle after E+4 (4-cycle bubble).
- instruction_valid=0 in the cycle after any redirect edge, and remains 0 until the refilled word arrives.
- Sustained throughput with ready=1 is one instruction per 3 cycles, with rom_read continuously high.
- With ready=0, fetch stops once QUEUE_DEPTH words are buffered; rom_read=0 thereafter.
- A pop at edge P re-enables issue from the cycle after P.
- reset asserted mid-operation clears all state and outputs immediately (no clock needed). Any partial instruction is lost.

## Test plan
- **Basic fetch.** Reset release, ROM[0..5]=01 23 45 67 89 AB, ready=1 → 0x012345 @0 is valid in the 5th cycle after the first edge, then 0x6789AB @3 exactly 3 cycles later.
- **Backpressure.** ready=0 → two words are buffered, rom_read drops to 0, and valid holds 0x012345 @0. Raising ready → 0x012345 then 0x6789AB are popped in order, and rom_read resumes with address 6 the cycle after the first pop.
- **Redirect mid-assembly.** ROM[0x100..0x102]=AA BB CC, redirect to 0x100 after byte 1 of an instruction → valid=0 for 4 cycles, next word is 0xAABBCC @0x100, no stale byte appears.
- **Redirect with full FIFO and simultaneous handshake.** Redirect with valid&ready at the same edge → the popped word is not repeated, the second buffered word never appears, and the next word comes from the redirect target.
- **Wrap.** Redirect to 0x7FFF with ROM[0x7FFF]=11, ROM[0]=22, ROM[1]=33 → 0x112233 @0x7FFF, and the next word is @0x0002.
- **Async reset mid-operation.** reset=0 between edges while the FIFO is non-empty → instruction_valid and rom_read are 0 immediately. On release, fetch restarts at RESET_VECTOR with the Basic fetch timing.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: reads the byte-wide instruction ROM, assembles big-endian 24-bit words
// and hands them to the execute core through a small FIFO with a valid/ready handshake.
module instruction_fetch #(
   parameter int                       ADDRESS_WIDTH = 15,
   parameter int                       QUEUE_DEPTH   = 2,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   output logic [ADDRESS_WIDTH-1:0] rom_address,
   output logic                     rom_read,
   input  logic [7:0]               rom_data,
   output logic [23:0]              instruction,
   output logic [ADDRESS_WIDTH-1:0] instruction_address,
   output logic                     instruction_valid,
   input  logic                     instruction_ready,
   input  logic                     redirect,
   input  logic [ADDRESS_WIDTH-1:0] redirect_address,
   output logic [1:0]               debug_state
);

   // Handshake: a word moves to the core at a rising edge where instruction_valid and
   // instruction_ready are both 1; the head is held stable while valid is 1 and ready is 0.

   typedef enum logic [1:0] {
      BYTE0 = 2'd0,
      BYTE1 = 2'd1,
      BYTE2 = 2'd2
   } asm_state_e;

   localparam int AW = ADDRESS_WIDTH;
   localparam int CW = $clog2(QUEUE_DEPTH + 2);

   asm_state_e           asm_q, asm_d;
   logic [1:0]           iss_q, iss_d;
   logic [AW-1:0]        ptr_q, ptr_d;
   logic                 rd_q, rd_d;
   logic [AW-1:0]        raddr_q, raddr_d;
   logic                 pend_q, pend_d;
   logic [AW-1:0]        pend_addr_q, pend_addr_d;
   logic [15:0]          word_q, word_d;
   logic [AW-1:0]        waddr_q, waddr_d;
   logic [23:0]          fdata_q [QUEUE_DEPTH];
   logic [23:0]          fdata_d [QUEUE_DEPTH];
   logic [AW-1:0]        faddr_q [QUEUE_DEPTH];
   logic [AW-1:0]        faddr_d [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] fvld_q, fvld_d;

   logic                 push;
   logic                 pop;
   logic                 placed;
   logic [CW-1:0]        count_d;
   logic                 inprog_d;
   logic                 start_ok;

   always_comb begin
      asm_d       = asm_q;
      iss_d       = iss_q;
      ptr_d       = ptr_q;
      rd_d        = 1'b0;
      raddr_d     = raddr_q;
      pend_d      = rd_q;
      pend_addr_d = raddr_q;
      word_d      = word_q;
      waddr_d     = waddr_q;
      fdata_d     = fdata_q;
      faddr_d     = faddr_q;
      fvld_d      = fvld_q;
      push        = 1'b0;
      placed      = 1'b0;
      count_d     = '0;
      inprog_d    = 1'b0;
      start_ok    = 1'b0;
      pop         = fvld_q[0] & instruction_ready;

      // pend_q marks that rom_data carries the byte read in the previous cycle
      if (pend_q) begin
         case (asm_q)
            BYTE0: begin
               word_d[15:8] = rom_data;
               waddr_d      = pend_addr_q;
               asm_d        = BYTE1;
            end
            BYTE1: begin
               word_d[7:0] = rom_data;
               asm_d       = BYTE2;
            end
            BYTE2: begin
               push  = 1'b1;
               asm_d = BYTE0;
            end
            default: asm_d = BYTE0;
         endcase
      end

      if (pop) begin
         for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
            fdata_d[i] = fdata_q[i+1];
            faddr_d[i] = faddr_q[i+1];
         end
         fvld_d = fvld_q >> 1;
      end

      if (push) begin
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (!fvld_d[i] && !placed) begin
               fdata_d[i] = {word_q, rom_data};
               faddr_d[i] = waddr_q;
               fvld_d[i]  = 1'b1;
               placed     = 1'b1;
            end
         end
      end

      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         count_d = count_d + CW'(fvld_d[i]);
      end
      // A started instruction holds a slot until its word lands in the FIFO
      inprog_d = (asm_d != BYTE0) | pend_d;
      start_ok = (count_d + CW'(inprog_d)) < CW'(QUEUE_DEPTH);

      if (redirect) begin
         rd_d    = 1'b1;
         raddr_d = redirect_address;
         ptr_d   = redirect_address + AW'(1);
         iss_d   = 2'd2;
         fvld_d  = '0;
         asm_d   = BYTE0;
         pend_d  = 1'b0;
      end else if (iss_q != 2'd0) begin
         rd_d    = 1'b1;
         raddr_d = ptr_q;
         ptr_d   = ptr_q + AW'(1);
         iss_d   = iss_q - 2'd1;
      end else if (start_ok) begin
         rd_d    = 1'b1;
         raddr_d = ptr_q;
         ptr_d   = ptr_q + AW'(1);
         iss_d   = 2'd2;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         asm_q       <= BYTE0;
         iss_q       <= 2'd0;
         ptr_q       <= RESET_VECTOR;
         rd_q        <= 1'b0;
         raddr_q     <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         word_q      <= '0;
         waddr_q     <= '0;
         fvld_q      <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            fdata_q[i] <= '0;
            faddr_q[i] <= '0;
         end
      end else begin
         asm_q       <= asm_d;
         iss_q       <= iss_d;
         ptr_q       <= ptr_d;
         rd_q        <= rd_d;
         raddr_q     <= raddr_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         word_q      <= word_d;
         waddr_q     <= waddr_d;
         fvld_q      <= fvld_d;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            fdata_q[i] <= fdata_d[i];
            faddr_q[i] <= faddr_d[i];
         end
      end
   end

   assign rom_read            = rd_q;
   assign rom_address         = raddr_q;
   assign instruction         = fdata_q[0];
   assign instruction_address = faddr_q[0];
   assign instruction_valid   = fvld_q[0];
   assign debug_state         = asm_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed cycle-by-cycle bench for instruction_fetch with a behavioural one-cycle ROM.
module tb_instruction_fetch;

   logic        clock;
   logic        reset;
   logic [14:0] rom_address;
   logic        rom_read;
   logic [7:0]  rom_data;
   logic [23:0] instruction;
   logic [14:0] instruction_address;
   logic        instruction_valid;
   logic        instruction_ready;
   logic        redirect;
   logic [14:0] redirect_address;
   logic [1:0]  debug_state;

   instruction_fetch dut (
      .clock               (clock),
      .reset               (reset),
      .rom_address         (rom_address),
      .rom_read            (rom_read),
      .rom_data            (rom_data),
      .instruction         (instruction),
      .instruction_address (instruction_address),
      .instruction_valid   (instruction_valid),
      .instruction_ready   (instruction_ready),
      .redirect            (redirect),
      .redirect_address    (redirect_address),
      .debug_state         (debug_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ROM: data for a read in cycle C is presented during C+1
   logic [7:0] rom [0:32767];
   initial rom_data = 8'h00;
   always @(posedge clock) if (rom_read) rom_data <= rom[rom_address];

   typedef struct {
      logic        ready;
      logic        redir;
      logic [14:0] raddr;
      logic        ev;
      logic [23:0] ei;
      logic [14:0] ea;
      logic        erd;
      logic [14:0] era;
   } vec_t;

   vec_t tab[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic add(input int r, input int rd, input int ra, input int ev,
                      input int ei, input int ea, input int erd, input int era);
      vec_t v;
      v.ready = r[0];
      v.redir = rd[0];
      v.raddr = 15'(ra);
      v.ev    = ev[0];
      v.ei    = 24'(ei);
      v.ea    = 15'(ea);
      v.erd   = erd[0];
      v.era   = 15'(era);
      tab.push_back(v);
   endtask

   task automatic chk(input string ph, input string fld, input int idx,
                      input logic [31:0] got, input logic [31:0] want);
      if (got !== want) begin
         n_err++;
         $display("FAIL %s.%s[%0d]: got %h want %h", ph, fld, idx, got, want);
      end
   endtask

   task automatic check_zero(input string ph);
      n_vec++;
      chk(ph, "valid", 0, 32'(instruction_valid), 32'd0);
      chk(ph, "instr", 0, 32'(instruction), 32'd0);
      chk(ph, "iaddr", 0, 32'(instruction_address), 32'd0);
      chk(ph, "rom_read", 0, 32'(rom_read), 32'd0);
      chk(ph, "rom_addr", 0, 32'(rom_address), 32'd0);
      chk(ph, "state", 0, 32'(debug_state), 32'd0);
   endtask

   // caller is at a negedge; each entry checks this cycle, then drives inputs for the next edge
   task automatic run_tab(input string ph);
      for (int i = 0; i < tab.size(); i++) begin
         n_vec++;
         chk(ph, "valid", i, 32'(instruction_valid), 32'(tab[i].ev));
         if (tab[i].ev) begin
            chk(ph, "instr", i, 32'(instruction), 32'(tab[i].ei));
            chk(ph, "iaddr", i, 32'(instruction_address), 32'(tab[i].ea));
         end
         chk(ph, "rom_read", i, 32'(rom_read), 32'(tab[i].erd));
         if (tab[i].erd) chk(ph, "rom_addr", i, 32'(rom_address), 32'(tab[i].era));
         instruction_ready = tab[i].ready;
         redirect          = tab[i].redir;
         redirect_address  = tab[i].raddr;
         @(negedge clock);
      end
      tab.delete();
   endtask

   initial begin
      for (int a = 0; a < 32768; a++) rom[a] = 8'(a);
      rom[0] = 8'h01; rom[1] = 8'h23; rom[2] = 8'h45;
      rom[3] = 8'h67; rom[4] = 8'h89; rom[5] = 8'hAB;
      rom[15'h100] = 8'hAA; rom[15'h101] = 8'hBB; rom[15'h102] = 8'hCC;

      reset = 1'b0;
      instruction_ready = 1'b0;
      redirect = 1'b0;
      redirect_address = '0;
      #1 check_zero("reset_state");
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // basic fetch, redirect mid-assembly, redirect with full FIFO + handshake
      add(1,0,0,      0,0,0,              0,0);
      add(1,0,0,      0,0,0,              1,0);
      add(1,0,0,      0,0,0,              1,1);
      add(1,0,0,      0,0,0,              1,2);
      add(1,0,0,      0,0,0,              1,3);
      add(1,0,0,      1,'h012345,0,       1,4);
      add(1,0,0,      0,0,0,              1,5);
      add(1,0,0,      0,0,0,              1,6);
      add(1,0,0,      1,'h6789AB,3,       1,7);
      add(1,0,0,      0,0,0,              1,8);
      add(1,0,0,      0,0,0,              1,9);
      add(1,0,0,      1,'h060708,6,       1,'hA);
      add(1,1,'h100,  0,0,0,              1,'hB);
      add(1,0,0,      0,0,0,              1,'h100);
      add(1,0,0,      0,0,0,              1,'h101);
      add(1,0,0,      0,0,0,              1,'h102);
      add(1,0,0,      0,0,0,              1,'h103);
      add(0,0,0,      1,'hAABBCC,'h100,   1,'h104);
      add(0,0,0,      1,'hAABBCC,'h100,   1,'h105);
      add(0,0,0,      1,'hAABBCC,'h100,   0,0);
      add(0,0,0,      1,'hAABBCC,'h100,   0,0);
      add(0,0,0,      1,'hAABBCC,'h100,   0,0);
      add(1,1,'h200,  1,'hAABBCC,'h100,   0,0);
      add(1,0,0,      0,0,0,              1,'h200);
      add(1,0,0,      0,0,0,              1,'h201);
      add(1,0,0,      0,0,0,              1,'h202);
      add(1,0,0,      0,0,0,              1,'h203);
      add(1,0,0,      1,'h000102,'h200,   1,'h204);
      add(1,0,0,      0,0,0,              1,'h205);
      add(1,0,0,      0,0,0,              1,'h206);
      add(0,0,0,      1,'h030405,'h203,   1,'h207);
      run_tab("fetch");

      // async reset between edges while the FIFO holds a word
      n_vec++;
      chk("pre_reset", "valid", 0, 32'(instruction_valid), 32'd1);
      chk("pre_reset", "instr", 0, 32'(instruction), 32'h030405);
      @(posedge clock);
      #2 reset = 1'b0;
      #1 check_zero("async_reset");
      repeat (2) @(negedge clock);
      check_zero("reset_held");
      reset = 1'b1;

      // restart from the reset vector under backpressure
      add(0,0,0,      0,0,0,              0,0);
      add(0,0,0,      0,0,0,              1,0);
      add(0,0,0,      0,0,0,              1,1);
      add(0,0,0,      0,0,0,              1,2);
      add(0,0,0,      0,0,0,              1,3);
      add(0,0,0,      1,'h012345,0,       1,4);
      add(0,0,0,      1,'h012345,0,       1,5);
      add(0,0,0,      1,'h012345,0,       0,0);
      add(0,0,0,      1,'h012345,0,       0,0);
      add(0,0,0,      1,'h012345,0,       0,0);
      add(0,0,0,      1,'h012345,0,       0,0);
      add(1,0,0,      1,'h012345,0,       0,0);
      add(1,0,0,      1,'h6789AB,3,       1,6);
      add(1,0,0,      0,0,0,              1,7);
      add(1,0,0,      0,0,0,              1,8);
      add(1,0,0,      0,0,0,              1,9);
      add(1,1,'h7FFF, 1,'h060708,6,       1,'hA);
      run_tab("backpressure");

      // address wrap, then redirect held for two edges
      rom[15'h7FFF] = 8'h11; rom[0] = 8'h22; rom[1] = 8'h33;
      add(1,0,0,      0,0,0,              1,'h7FFF);
      add(1,0,0,      0,0,0,              1,0);
      add(1,0,0,      0,0,0,              1,1);
      add(1,0,0,      0,0,0,              1,2);
      add(1,0,0,      1,'h112233,'h7FFF,  1,3);
      add(1,0,0,      0,0,0,              1,4);
      add(1,0,0,      0,0,0,              1,5);
      add(1,1,'h300,  1,'h456789,2,       1,6);
      add(1,1,'h310,  0,0,0,              1,'h300);
      add(1,0,0,      0,0,0,              1,'h310);
      add(1,0,0,      0,0,0,              1,'h311);
      add(1,0,0,      0,0,0,              1,'h312);
      add(1,0,0,      0,0,0,              1,'h313);
      add(1,0,0,      1,'h101112,'h310,   1,'h314);
      run_tab("wrap");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
